// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath widths, ALU function codes, opcodes and the
// decode control word carried between stages.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned FUNC_W = 6;

  localparam logic [5:0] ALU_NOP = 6'b000000;
  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_AND = 6'b100100;
  localparam logic [5:0] ALU_OR  = 6'b100101;
  localparam logic [5:0] ALU_XOR = 6'b100110;
  localparam logic [5:0] ALU_SLT = 6'b101010;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic mem_read;
    logic alu_src;
    logic reg_dst;
    logic branch;
  } ctrl_t;

  // All-zero control word: no register or memory write, so a bubble is side-effect free.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_hazard.sv
// Load-use hazard detector: flags a load in Execute whose destination is read in Decode.
module load_use_hazard #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              MemReadE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  output logic              LU
);

  // Matches RtD even when the decoded op does not read rt; conservative by design.
  assign LU = MemReadE & (RtE != '0) & ((RtE == RsD) | (RtE == RtD));

endmodule

// File: rtl/id_ex_stage_reg.sv
// Decode->Execute pipeline register with load-use stall and branch flush bubbles.
// Optional bubble counter port BubbleCnt is enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage_reg #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned REG_AW = mips_pkg::REG_AW,
  parameter int unsigned FUNC_W = mips_pkg::FUNC_W
`ifdef ID_EX_STALL_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteD,
  input  logic              MemToRegD,
  input  logic              MemWriteD,
  input  logic              MemReadD,
  input  logic              ALUSrcD,
  input  logic              RegDstD,
  input  logic              BranchD,
  input  logic [FUNC_W-1:0] ALUfuncD,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [DATA_W-1:0] SignImmD,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RdD,
  input  logic              FlushE,
  output logic              RegWriteE,
  output logic              MemToRegE,
  output logic              MemWriteE,
  output logic              MemReadE,
  output logic              ALUSrcE,
  output logic              RegDstE,
  output logic              BranchE,
  output logic [FUNC_W-1:0] ALUfuncE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] SignImmE,
  output logic [REG_AW-1:0] RsE,
  output logic [REG_AW-1:0] RtE,
  output logic [REG_AW-1:0] RdE,
  output logic              StallF,
  output logic              StallD
`ifdef ID_EX_STALL_CNT_EN
  , output logic [CNT_W-1:0] BubbleCnt
`endif
);

  import mips_pkg::*;

  logic  lu;
  logic  bubble;
  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  load_use_hazard #(
    .REG_AW (REG_AW)
  ) u_load_use_hazard (
    .MemReadE (MemReadE),
    .RtE      (RtE),
    .RsD      (RsD),
    .RtD      (RtD),
    .LU       (lu)
  );

  assign StallF = lu;
  assign StallD = lu;
  assign bubble = lu | FlushE;

  always_comb begin
    ctrl_d            = CTRL_BUBBLE;
    ctrl_d.reg_write  = RegWriteD;
    ctrl_d.mem_to_reg = MemToRegD;
    ctrl_d.mem_write  = MemWriteD;
    ctrl_d.mem_read   = MemReadD;
    ctrl_d.alu_src    = ALUSrcD;
    ctrl_d.reg_dst    = RegDstD;
    ctrl_d.branch     = BranchD;
  end

  // Bubbles also zero the specifiers so RtE = 0 cannot retrigger the load-use stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= CTRL_BUBBLE;
      ALUfuncE <= FUNC_W'(ALU_NOP);
      RD1E     <= '0;
      RD2E     <= '0;
      SignImmE <= '0;
      RsE      <= '0;
      RtE      <= '0;
      RdE      <= '0;
    end else if (bubble) begin
      ctrl_q   <= CTRL_BUBBLE;
      ALUfuncE <= FUNC_W'(ALU_NOP);
      RD1E     <= '0;
      RD2E     <= '0;
      SignImmE <= '0;
      RsE      <= '0;
      RtE      <= '0;
      RdE      <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      ALUfuncE <= ALUfuncD;
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      SignImmE <= SignImmD;
      RsE      <= RsD;
      RtE      <= RtD;
      RdE      <= RdD;
    end
  end

  assign RegWriteE = ctrl_q.reg_write;
  assign MemToRegE = ctrl_q.mem_to_reg;
  assign MemWriteE = ctrl_q.mem_write;
  assign MemReadE  = ctrl_q.mem_read;
  assign ALUSrcE   = ctrl_q.alu_src;
  assign RegDstE   = ctrl_q.reg_dst;
  assign BranchE   = ctrl_q.branch;

`ifdef ID_EX_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BubbleCnt <= '0;
    end else if (bubble && (BubbleCnt != '1)) begin
      BubbleCnt <= BubbleCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed pipeline scenarios plus random traffic.
module tb_id_ex_stage_reg;

  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic        mw;
    logic        mr;
    logic        as;
    logic        rdst;
    logic        br;
    logic [5:0]  func;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } e_t;

  typedef struct packed {
    logic        stall;
    e_t          e;
    int unsigned cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        RegWriteD, MemToRegD, MemWriteD, MemReadD, ALUSrcD, RegDstD, BranchD, FlushE;
  logic [5:0]  ALUfuncD;
  logic [31:0] RD1D, RD2D, SignImmD;
  logic [4:0]  RsD, RtD, RdD;
  logic        RegWriteE, MemToRegE, MemWriteE, MemReadE, ALUSrcE, RegDstE, BranchE;
  logic [5:0]  ALUfuncE;
  logic [31:0] RD1E, RD2E, SignImmE;
  logic [4:0]  RsE, RtE, RdE;
  logic        StallF, StallD;
  logic [CW-1:0] bubble_cnt;

`ifdef ID_EX_STALL_CNT_EN
  id_ex_stage_reg #(.CNT_W(CW)) dut (
`else
  id_ex_stage_reg dut (
`endif
    .clk(clk), .rst(rst),
    .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .MemWriteD(MemWriteD),
    .MemReadD(MemReadD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .BranchD(BranchD),
    .ALUfuncD(ALUfuncD), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE),
    .MemReadE(MemReadE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .BranchE(BranchE),
    .ALUfuncE(ALUfuncE), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
    .RsE(RsE), .RtE(RtE), .RdE(RdE),
`ifdef ID_EX_STALL_CNT_EN
    .StallF(StallF), .StallD(StallD), .BubbleCnt(bubble_cnt)
`else
    .StallF(StallF), .StallD(StallD)
`endif
  );

`ifndef ID_EX_STALL_CNT_EN
  assign bubble_cnt = '0;
`endif

  exp_t        exp_q[$];
  e_t          model_e = '0;
  int unsigned model_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  function automatic e_t dut_e();
    return {RegWriteE, MemToRegE, MemWriteE, MemReadE, ALUSrcE, RegDstE, BranchE,
            ALUfuncE, RD1E, RD2E, SignImmE, RsE, RtE, RdE};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic apply(input e_t d, input logic fl);
    RegWriteD = d.rw;   MemToRegD = d.m2r;  MemWriteD = d.mw;  MemReadD = d.mr;
    ALUSrcD   = d.as;   RegDstD   = d.rdst; BranchD   = d.br;  ALUfuncD = d.func;
    RD1D      = d.rd1;  RD2D      = d.rd2;  SignImmD  = d.imm;
    RsD       = d.rs;   RtD       = d.rt;   RdD       = d.rd;  FlushE   = fl;
  endtask

  // Reference: a load in E whose nonzero destination is named in D costs one bubble;
  // a flush also costs one bubble; otherwise D moves into E unchanged.
  task automatic step(input e_t d, input logic fl, output logic stall);
    exp_t x;
    @(posedge clk);
    #2;
    apply(d, fl);
    stall = model_e.mr && (model_e.rt != 0) && ((model_e.rt == d.rs) || (model_e.rt == d.rt));
    x.stall = stall;
    if (stall || fl) begin
      model_e = '0;
      if (model_cnt < CMAX) model_cnt++;
    end else begin
      model_e = d;
    end
    x.e   = model_e;
    x.cnt = model_cnt;
    exp_q.push_back(x);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        check("stallf", 128'(StallF), 128'(exp_q[0].stall));
        check("stalld", 128'(StallD), 128'(exp_q[0].stall));
      end
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("e_regs", 128'(dut_e()), 128'(x.e));
`ifdef ID_EX_STALL_CNT_EN
        check("bubble_cnt", 128'(bubble_cnt), 128'(x.cnt));
`endif
      end
    end
  end

  initial begin
    e_t   z, d, addi, lw8, add8, lw0, add0, sw;
    logic st, fl;
    z = '0;
    apply(z, 1'b0);
    #12;
    check("reset_e", 128'(dut_e()), 128'(0));
    check("reset_cnt", 128'(bubble_cnt), 128'(0));
    rst = 1'b0;

    // Async reset mid-cycle after RegWriteD has been captured.
    d = z; d.rw = 1'b1; d.rt = 5'd3;
    apply(d, 1'b0);
    @(posedge clk); #3;
    check("pre_async_rw", 128'(RegWriteE), 128'(1));
    rst = 1'b1;
    #1;
    check("async_reset_e", 128'(dut_e()), 128'(0));
    check("async_reset_cnt", 128'(bubble_cnt), 128'(0));
    apply(z, 1'b0);
    @(posedge clk); #3;
    rst = 1'b0;
    model_e = '0; model_cnt = 0;

    addi = z; addi.rw = 1; addi.as = 1; addi.func = 6'b100000; addi.rt = 5; addi.imm = 7;
    lw8  = z; lw8.rw = 1; lw8.m2r = 1; lw8.mr = 1; lw8.as = 1; lw8.func = 6'b100000;
    lw8.rs = 1; lw8.rt = 8; lw8.imm = 32'h10;
    add8 = z; add8.rw = 1; add8.rdst = 1; add8.func = 6'b100000; add8.rs = 8; add8.rt = 2;
    add8.rd = 9; add8.rd1 = 32'hdead_beef; add8.rd2 = 32'h1234;
    lw0  = lw8; lw0.rt = 0;
    add0 = add8; add0.rs = 0;
    sw   = z; sw.mw = 1; sw.as = 1; sw.rs = 4; sw.rt = 6; sw.imm = 32'h20; sw.func = 6'b100000;

    step(addi, 1'b0, st);
    step(z, 1'b0, st);
    step(lw8, 1'b0, st);
    step(add8, 1'b0, st);
    step(add8, 1'b0, st);
    step(lw0, 1'b0, st);
    step(add0, 1'b0, st);
    step(sw, 1'b1, st);
    step(lw8, 1'b0, st);
    step(add8, 1'b1, st);
    step(add8, 1'b0, st);

    // Random traffic; a stalled instruction is re-presented, as the held IF/ID would do.
    d = z; st = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!st) begin
        d.rw = 1'($urandom); d.m2r = 1'($urandom); d.mw = 1'($urandom);
        d.mr = 1'($urandom); d.as = 1'($urandom); d.rdst = 1'($urandom);
        d.br = 1'($urandom); d.func = 6'($urandom);
        d.rd1 = $urandom; d.rd2 = $urandom; d.imm = $urandom;
        d.rs = 5'($urandom_range(0, 3)); d.rt = 5'($urandom_range(0, 3));
        d.rd = 5'($urandom);
      end
      fl = ($urandom_range(0, 7) == 0);
      step(d, fl, st);
    end

    for (int i = 0; i < 20; i++) step(sw, 1'b1, st);
    step(z, 1'b0, st);

    // Reset while a stall is being asserted.
    step(lw8, 1'b0, st);
    step(add8, 1'b0, st);
    #2;
    exp_q.delete();
    rst = 1'b1;
    #1;
    check("rst_mid_stall_e", 128'(dut_e()), 128'(0));
    check("rst_mid_stall_stall", 128'(StallF), 128'(0));
    apply(z, 1'b0);
    @(posedge clk); #3;
    rst = 1'b0;
    model_e = '0; model_cnt = 0;
    #1;
    check("post_reset_stall", 128'(StallD), 128'(0));
    step(add8, 1'b0, st);
    step(z, 1'b0, st);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #5;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
